// File: rtl/frame_draw_ctrl_pkg.sv
// Shared types and constants for the frame draw controller and its pixel walker.
package frame_draw_ctrl_pkg;

  localparam int unsigned X_W = 8;
  localparam int unsigned Y_W = 7;
  localparam int unsigned C_W = 3;

  localparam int unsigned DEF_SQ_DIM          = 4;
  localparam int unsigned DEF_STEPS_PER_FRAME = 81;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_LATCH  = 3'd2,
    ST_DRAW   = 3'd3,
    ST_STEP   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [C_W-1:0] COL_BLACK   = 3'b000;
  localparam logic [C_W-1:0] COL_BLUE    = 3'b001;
  localparam logic [C_W-1:0] COL_GREEN   = 3'b010;
  localparam logic [C_W-1:0] COL_CYAN    = 3'b011;
  localparam logic [C_W-1:0] COL_RED     = 3'b100;
  localparam logic [C_W-1:0] COL_MAGENTA = 3'b101;
  localparam logic [C_W-1:0] COL_YELLOW  = 3'b110;
  localparam logic [C_W-1:0] COL_WHITE   = 3'b111;

endpackage

// File: rtl/frame_draw_ctrl_walker.sv
// Walks a SQ_DIM x SQ_DIM square: pixel counter plus x/y offset adders.
module square_pixel_walker
  import frame_draw_ctrl_pkg::*;
#(
  parameter int unsigned SQ_DIM = DEF_SQ_DIM
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           clear,
  input  logic           advance,
  input  logic [X_W-1:0] base_x,
  input  logic [Y_W-1:0] base_y,
  output logic [X_W-1:0] pix_x_c,
  output logic [Y_W-1:0] pix_y_c,
  output logic           last_c
);

  localparam int unsigned LOG_W = $clog2(SQ_DIM);
  localparam int unsigned PIX_W = 2 * LOG_W;

  logic [PIX_W-1:0] pix_cnt;
  logic [LOG_W-1:0] col;
  logic [LOG_W-1:0] row;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pix_cnt <= '0;
    end else if (clear) begin
      pix_cnt <= '0;
    end else if (advance) begin
      pix_cnt <= pix_cnt + PIX_W'(1);
    end
  end

  // Low half of the counter is the column, high half the row; sums wrap at the screen width.
  assign col     = pix_cnt[LOG_W-1:0];
  assign row     = pix_cnt[PIX_W-1:LOG_W];
  assign pix_x_c = base_x + X_W'(col);
  assign pix_y_c = base_y + Y_W'(row);
  assign last_c  = (pix_cnt == {PIX_W{1'b1}});

endmodule

// File: rtl/frame_draw_ctrl.sv
// Per-frame redraw controller: steps the square sequencer and plots each drawable square.
module frame_draw_ctrl
  import frame_draw_ctrl_pkg::*;
#(
  parameter int unsigned SQ_DIM          = DEF_SQ_DIM,
  parameter int unsigned STEPS_PER_FRAME = DEF_STEPS_PER_FRAME
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           frame_tick,
  input  logic [X_W-1:0] sq_x,
  input  logic [Y_W-1:0] sq_y,
  input  logic [C_W-1:0] sq_colour,
  input  logic           sq_is_swap,
  output logic           sq_step,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [C_W-1:0] vga_colour,
  output logic           vga_plot,
  output logic           shift_en,
  output logic           busy,
  output logic           overrun
);

  localparam int unsigned STEP_W = (STEPS_PER_FRAME > 1) ? $clog2(STEPS_PER_FRAME) : 1;

  state_t            state;
  state_t            next_state;
  logic [STEP_W-1:0] step_cnt;
  logic [X_W-1:0]    lat_x;
  logic [Y_W-1:0]    lat_y;
  logic [C_W-1:0]    lat_colour;
  logic              walk_clear;
  logic              walk_adv;
  logic [X_W-1:0]    pix_x;
  logic [Y_W-1:0]    pix_y;
  logic              pix_last;

  square_pixel_walker #(
    .SQ_DIM (SQ_DIM)
  ) u_walker (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (walk_clear),
    .advance (walk_adv),
    .base_x  (lat_x),
    .base_y  (lat_y),
    .pix_x_c (pix_x),
    .pix_y_c (pix_y),
    .last_c  (pix_last)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    walk_clear = 1'b0;
    walk_adv   = 1'b0;
    case (state)
      ST_IDLE:   if (frame_tick) next_state = ST_SETTLE;
      ST_SETTLE: next_state = ST_LATCH;
      ST_LATCH: begin
        walk_clear = 1'b1;
        next_state = sq_is_swap ? ST_STEP : ST_DRAW;
      end
      ST_DRAW: begin
        walk_adv = 1'b1;
        if (pix_last) next_state = ST_STEP;
      end
      ST_STEP: begin
        if (step_cnt == STEP_W'(STEPS_PER_FRAME - 1)) next_state = ST_DONE;
        else                                         next_state = ST_SETTLE;
      end
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs; pulses are the registered image of their state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      step_cnt   <= '0;
      lat_x      <= '0;
      lat_y      <= '0;
      lat_colour <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      sq_step    <= 1'b0;
      shift_en   <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (state == ST_LATCH) begin
        lat_x      <= sq_x;
        lat_y      <= sq_y;
        lat_colour <= sq_colour;
      end
      if (state == ST_STEP) begin
        step_cnt <= step_cnt + STEP_W'(1);
      end else if (state == ST_DONE) begin
        step_cnt <= '0;
      end
      if (state == ST_DRAW) begin
        vga_x      <= pix_x;
        vga_y      <= pix_y;
        vga_colour <= lat_colour;
      end
      vga_plot <= (state == ST_DRAW);
      sq_step  <= (state == ST_STEP);
      shift_en <= (state == ST_DONE);
      busy     <= (next_state != ST_IDLE);
      if (frame_tick && (state != ST_IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_draw_ctrl.sv
// Directed bench for frame_draw_ctrl with a behavioural square-sequencer model.
module tb_frame_draw_ctrl;

  logic       clk;
  logic       resetn;
  logic       frame_tick;
  logic [7:0] sq_x;
  logic [6:0] sq_y;
  logic [2:0] sq_colour;
  logic       sq_is_swap;
  logic       sq_step;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       shift_en;
  logic       busy;
  logic       overrun;

  int errors = 0;
  int checks = 0;

  int mode = 0;
  int seq_idx = 0;
  logic seq_clr = 1'b0;

  int plots = 0, steps = 0, shifts = 0, pk = 0;
  int p0 = 0, s0 = 0, h0 = 0;
  logic [18:0] mon_w;
  logic [7:0]  ex;
  logic [6:0]  ey;
  logic [7:0]  cap_x [16];
  logic [6:0]  cap_y [16];

  frame_draw_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .frame_tick (frame_tick),
    .sq_x       (sq_x),
    .sq_y       (sq_y),
    .sq_colour  (sq_colour),
    .sq_is_swap (sq_is_swap),
    .sq_step    (sq_step),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .shift_en   (shift_en),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sequencer model: {swap, colour, y, x} for step idx under stimulus mode m.
  function automatic logic [18:0] seq_word(input int m, input int idx);
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       s;
    case (m)
      0: begin x = 8'd1;   y = 7'd53;  c = 3'b100; s = 1'b0; end
      1: begin x = 8'(idx * 4); y = 7'(idx); c = 3'(idx); s = ((idx % 27) == 26); end
      2: begin x = 8'd254; y = 7'd126; c = 3'b010; s = 1'b0; end
      default: begin x = 8'd9; y = 7'd9; c = 3'b001; s = 1'b1; end
    endcase
    return {s, c, y, x};
  endfunction

  assign {sq_is_swap, sq_colour, sq_y, sq_x} = seq_word(mode, seq_idx);

  always @(posedge clk) begin
    if (seq_clr)      seq_idx <= 0;
    else if (sq_step) seq_idx <= seq_idx + 1;
  end

  // Output monitor: every plotted pixel is checked against base + (col,row) of the current square.
  always @(negedge clk) begin
    if (!resetn) begin
      pk = 0;
    end else begin
      if (vga_plot) begin
        mon_w = seq_word(mode, seq_idx);
        ex = mon_w[7:0] + 8'(pk % 4);
        ey = mon_w[14:8] + 7'(pk / 4);
        chk("pix", {14'd0, vga_x, vga_y, vga_colour}, {14'd0, ex, ey, mon_w[17:15]});
        if (seq_idx == 0 && pk < 16) begin
          cap_x[pk] = vga_x;
          cap_y[pk] = vga_y;
        end
        plots++;
        pk++;
      end
      if (sq_step) begin
        steps++;
        pk = 0;
      end
      if (shift_en) begin
        shifts++;
        chk("shift_vs_plot", 32'(vga_plot), 32'd0);
      end
    end
  end

  task automatic new_frame(input int m);
    mode = m;
    @(negedge clk) seq_clr = 1'b1;
    @(negedge clk) begin seq_clr = 1'b0; frame_tick = 1'b1; end
    p0 = plots; s0 = steps; h0 = shifts;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  // Edges until vga_plot (which=0) or sq_step (which=1) is seen.
  task automatic count_until(input int which, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((which == 0) ? vga_plot : sq_step) && n < 100);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    resetn = 1'b0;
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_x", 32'(vga_x), 32'd0);
    chk("rst_y", 32'(vga_y), 32'd0);
    chk("rst_colour", 32'(vga_colour), 32'd0);
    chk("rst_plot", 32'(vga_plot), 32'd0);
    chk("rst_step", 32'(sq_step), 32'd0);
    chk("rst_shift", 32'(shift_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    @(negedge clk) resetn = 1'b1;

    // Plain squares at (1,53), red: latency and per-square cost.
    new_frame(0);
    chk("busy_high", 32'(busy), 32'd1);
    count_until(0, n);
    chk("lat_plot", 32'(n), 32'd3);
    count_until(1, n);
    chk("lat_step0", 32'(n), 32'd16);
    count_until(1, n);
    chk("gap_draw", 32'(n), 32'd19);
    wait_idle();
    chk("a_plots", 32'(plots - p0), 32'd1296);
    chk("a_steps", 32'(steps - s0), 32'd81);
    chk("a_shifts", 32'(shifts - h0), 32'd1);
    chk("a_overrun", 32'(overrun), 32'd0);

    // Row-swap state every 27th step: 78 drawn squares.
    new_frame(1);
    wait_idle();
    chk("b_plots", 32'(plots - p0), 32'd1248);
    chk("b_steps", 32'(steps - s0), 32'd81);
    chk("b_shifts", 32'(shifts - h0), 32'd1);

    // Square at the screen corner wraps in both axes.
    new_frame(2);
    wait_idle();
    chk("wrap_x0", 32'(cap_x[0]), 32'd254);
    chk("wrap_x1", 32'(cap_x[1]), 32'd255);
    chk("wrap_x2", 32'(cap_x[2]), 32'd0);
    chk("wrap_x3", 32'(cap_x[3]), 32'd1);
    chk("wrap_y0", 32'(cap_y[0]), 32'd126);
    chk("wrap_y1", 32'(cap_y[4]), 32'd127);
    chk("wrap_y2", 32'(cap_y[8]), 32'd0);
    chk("wrap_y3", 32'(cap_y[12]), 32'd1);
    chk("c_plots", 32'(plots - p0), 32'd1296);

    // All swap states: no pixels, three cycles per step.
    new_frame(3);
    count_until(1, n);
    chk("swap_lat", 32'(n), 32'd3);
    count_until(1, n);
    chk("swap_gap", 32'(n), 32'd3);
    wait_idle();
    chk("d_plots", 32'(plots - p0), 32'd0);
    chk("d_steps", 32'(steps - s0), 32'd81);
    chk("d_shifts", 32'(shifts - h0), 32'd1);

    // Second tick during DRAW: flagged and otherwise ignored.
    new_frame(0);
    repeat (10) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    chk("ovr_set", 32'(overrun), 32'd1);
    wait_idle();
    chk("e_steps", 32'(steps - s0), 32'd81);
    chk("e_shifts", 32'(shifts - h0), 32'd1);
    repeat (40) @(negedge clk);
    chk("e_no_restart", 32'(busy), 32'd0);
    chk("e_steps_after", 32'(steps - s0), 32'd81);
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // Reset while drawing step 40 abandons the frame.
    new_frame(0);
    n = 0;
    while ((steps - s0) < 40 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("f_reach40", 32'(steps - s0), 32'd40);
    repeat (8) @(negedge clk);
    chk("f_drawing", 32'(vga_plot), 32'd1);
    #1 resetn = 1'b0;
    #1;
    chk("f_rst_xy", {13'd0, vga_x, vga_y, vga_colour, vga_plot}, 32'd0);
    chk("f_rst_pulses", {28'd0, sq_step, shift_en, busy, overrun}, 32'd0);
    repeat (3) @(negedge clk);
    chk("f_no_shift", 32'(shifts - h0), 32'd0);
    resetn = 1'b1;
    new_frame(0);
    wait_idle();
    chk("g_steps", 32'(steps - s0), 32'd81);
    chk("g_shifts", 32'(shifts - h0), 32'd1);
    chk("g_plots", 32'(plots - p0), 32'd1296);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
